// File: rtl/ui_input_sampler_pkg.sv
// rtl/ui_input_sampler_pkg.sv - shared constants for the UI input sampler
//
// Purpose: read-select encodings and per-input reset levels used by the
// sampler top level and its debounce cells.
// Ports: none (package).
package ui_input_sampler_pkg;

    // Read-select encodings seen on rdSel.
    localparam logic [1:0] RDSEL_KEYSTATE = 2'd0;
    localparam logic [1:0] RDSEL_SWSTATE  = 2'd1;
    localparam logic [1:0] RDSEL_KEYEVENT = 2'd2;
    localparam logic [1:0] RDSEL_STATUS   = 2'd3;

    // Idle level of each raw input group: keys are active-low, switches active-high.
    localparam logic KEY_RESET_LEVEL = 1'b1;
    localparam logic SW_RESET_LEVEL  = 1'b0;

endpackage

// File: rtl/ui_input_sampler_debounce_bit.sv
// rtl/ui_input_sampler_debounce_bit.sv - two-flop synchronizer plus counter debounce for one input bit
//
// Purpose: bring one asynchronous board input into the clk domain and accept a
// new level only after it has been stable for DEBOUNCE_CYCLES synced cycles.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   rawIn    in   raw asynchronous input
//   stable   out  debounced level, resets to RESET_LEVEL
module debounce_bit #(
    parameter int   DEBOUNCE_CYCLES = 10000,
    parameter int   CNT_BITS        = 14,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic rawIn,
    output logic stable
);

    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

    logic                meta;
    logic                synced;
    logic [CNT_BITS-1:0] counter;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta    <= RESET_LEVEL;
            synced  <= RESET_LEVEL;
            stable  <= RESET_LEVEL;
            counter <= '0;
        end else begin
            meta   <= rawIn;
            synced <= meta;
            // Any return to the stable level restarts the count, so only an
            // unbroken run of DEBOUNCE_CYCLES differing samples is accepted.
            if (synced == stable) begin
                counter <= '0;
            end else if (counter == CNT_LAST) begin
                stable  <= synced;
                counter <= '0;
            end else begin
                counter <= counter + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ui_input_sampler.sv
// rtl/ui_input_sampler.sv - debounced key/switch levels, sticky key events and overrun read port
//
// Purpose: debounce KEY and SW, capture key-press events with overrun
// tracking, and present them through a registered read port.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   KEY      in   raw keys, 0 = pressed
//   SW       in   raw switches
//   rdEn     in   read strobe, one cycle per read
//   rdSel    in   0 KEYSTATE, 1 SWSTATE, 2 KEYEVENT, 3 STATUS
//   rdData   out  registered, zero-extended read data
//   keyIrq   out  high while any key event is pending
module ui_input_sampler
    import ui_input_sampler_pkg::*;
#(
    parameter int DBITS           = 32,
    parameter int KEY_BITS        = 4,
    parameter int SW_BITS         = 10,
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int CNT_BITS        = 14
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [KEY_BITS-1:0] KEY,
    input  logic [SW_BITS-1:0]  SW,
    input  logic                rdEn,
    input  logic [1:0]          rdSel,
    output logic [DBITS-1:0]    rdData,
    output logic                keyIrq
);

    logic [KEY_BITS-1:0] stableKey;
    logic [SW_BITS-1:0]  stableSw;

    logic [KEY_BITS-1:0] pressed;
    logic [KEY_BITS-1:0] pressedD;
    logic [SW_BITS-1:0]  swLevel;
    logic [KEY_BITS-1:0] rise;

    logic [KEY_BITS-1:0] keyEvent;
    logic [KEY_BITS-1:0] overrun;
    logic [KEY_BITS-1:0] eventNext;
    logic [KEY_BITS-1:0] overrunNext;
    logic                eventClr;
    logic                statusClr;
    logic [DBITS-1:0]    readMux;

    genvar gi;
    for (gi = 0; gi < KEY_BITS; gi++) begin : gKey
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_BITS        (CNT_BITS),
            .RESET_LEVEL     (KEY_RESET_LEVEL)
        ) uDebounce (
            .clk     (clk),
            .reset_n (reset_n),
            .rawIn   (KEY[gi]),
            .stable  (stableKey[gi])
        );
    end

    for (gi = 0; gi < SW_BITS; gi++) begin : gSw
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_BITS        (CNT_BITS),
            .RESET_LEVEL     (SW_RESET_LEVEL)
        ) uDebounce (
            .clk     (clk),
            .reset_n (reset_n),
            .rawIn   (SW[gi]),
            .stable  (stableSw[gi])
        );
    end

    assign pressed = ~stableKey;
    assign swLevel = stableSw;
    assign rise    = pressed & ~pressedD;

    assign eventClr  = rdEn && (rdSel == RDSEL_KEYEVENT);
    assign statusClr = rdEn && (rdSel == RDSEL_STATUS);

    // A new press always survives a same-cycle clear, so it is never lost.
    assign eventNext   = rise | (keyEvent & ~{KEY_BITS{eventClr}});
    assign overrunNext = (rise & keyEvent & ~{KEY_BITS{eventClr}})
                       | (overrun & ~{KEY_BITS{statusClr}});

    // Event and status reads return the pre-update register value.
    always_comb begin
        readMux = '0;
        case (rdSel)
            RDSEL_KEYSTATE: readMux[KEY_BITS-1:0] = pressed;
            RDSEL_SWSTATE:  readMux[SW_BITS-1:0]  = swLevel;
            RDSEL_KEYEVENT: readMux[KEY_BITS-1:0] = keyEvent;
            default:        readMux[KEY_BITS-1:0] = overrun;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pressedD <= '0;
            keyEvent <= '0;
            overrun  <= '0;
            keyIrq   <= 1'b0;
            rdData   <= '0;
        end else begin
            pressedD <= pressed;
            keyEvent <= eventNext;
            overrun  <= overrunNext;
            keyIrq   <= |eventNext;
            if (rdEn) begin
                rdData <= readMux;
            end
        end
    end

endmodule

// File: tb/tb_ui_input_sampler.sv
// tb/tb_ui_input_sampler.sv - scoreboard bench for ui_input_sampler
module tb_ui_input_sampler;

    localparam int DBITS    = 32;
    localparam int KEY_BITS = 4;
    localparam int SW_BITS  = 10;
    localparam int DEB      = 4;
    localparam int CNT_BITS = 3;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [KEY_BITS-1:0] KEY;
    logic [SW_BITS-1:0]  SW;
    logic                rdEn;
    logic [1:0]          rdSel;
    logic [DBITS-1:0]    rdData;
    logic                keyIrq;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } expItem_t;

    expItem_t sbQueue[$];
    logic     rdIssued;

    always #5 clk = ~clk;

    ui_input_sampler #(
        .DBITS           (DBITS),
        .KEY_BITS        (KEY_BITS),
        .SW_BITS         (SW_BITS),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_BITS        (CNT_BITS)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .KEY     (KEY),
        .SW      (SW),
        .rdEn    (rdEn),
        .rdSel   (rdSel),
        .rdData  (rdData),
        .keyIrq  (keyIrq)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // A read accepted at a posedge produces rdData that is compared at the next negedge.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) rdIssued <= 1'b0;
        else          rdIssued <= rdEn;
    end

    always @(negedge clk) begin
        if (rdIssued) begin
            checkVal("sb_nonempty", 32'(sbQueue.size() != 0), 32'd1);
            if (sbQueue.size() != 0) begin
                expItem_t it;
                it = sbQueue.pop_front();
                checkVal(it.tag, rdData, it.exp);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic doRead(input logic [1:0] sel, input logic [31:0] exp, input string tag);
        sbQueue.push_back('{tag: tag, exp: exp});
        rdSel = sel;
        rdEn  = 1'b1;
        @(negedge clk);
        rdEn  = 1'b0;
    endtask

    task automatic cleanReset();
        reset_n = 1'b0;
        KEY     = 4'hF;
        SW      = '0;
        tick(2);
        reset_n = 1'b1;
        tick(3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic keySeq [7];
        reset_n = 1'b0;
        KEY     = 4'h0;
        SW      = 10'h3FF;
        rdEn    = 1'b0;
        rdSel   = 2'd0;

        // 1. Reset with all inputs active.
        tick(3);
        checkVal("t1_rst_rdData", rdData, 32'h0);
        checkVal("t1_rst_keyIrq", 32'(keyIrq), 32'h0);
        reset_n = 1'b1;
        doRead(2'd0, 32'h0, "t1_sel0_after_rst");
        cleanReset();

        // 2. Bounce rejection on KEY[0]: runs of 3 and 2 never reach 4.
        keySeq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            KEY[0] = keySeq[i];
            tick(1);
            checkVal("t2_irq_bounce", 32'(keyIrq), 32'h0);
        end
        tick(8);
        doRead(2'd0, 32'h0, "t2_sel0");
        doRead(2'd2, 32'h0, "t2_event");
        checkVal("t2_irq_end", 32'(keyIrq), 32'h0);

        // 3. Clean press on KEY[2].
        KEY[2] = 1'b0;
        tick(5);
        doRead(2'd0, 32'h0, "t3_sel0_before6");
        doRead(2'd0, 32'h4, "t3_sel0_at6");
        checkVal("t3_irq_set", 32'(keyIrq), 32'h1);
        doRead(2'd2, 32'h4, "t3_event");
        checkVal("t3_irq_clr", 32'(keyIrq), 32'h0);
        doRead(2'd2, 32'h0, "t3_event_again");
        KEY[2] = 1'b1;
        tick(8);
        doRead(2'd2, 32'h0, "t3_release_no_event");
        doRead(2'd0, 32'h0, "t3_released");

        // 4. Two presses of KEY[1] without reading.
        for (int p = 0; p < 2; p++) begin
            KEY[1] = 1'b0;
            tick(8);
            KEY[1] = 1'b1;
            tick(8);
        end
        checkVal("t4_irq", 32'(keyIrq), 32'h1);
        doRead(2'd2, 32'h2, "t4_event");
        doRead(2'd3, 32'h2, "t4_overrun");
        doRead(2'd3, 32'h0, "t4_overrun_cleared");
        checkVal("t4_irq_clr", 32'(keyIrq), 32'h0);

        // 5. Rise on KEY[3] lands in the same cycle as an event read.
        KEY[0] = 1'b0;
        tick(8);
        KEY[3] = 1'b0;
        tick(6);
        doRead(2'd2, 32'h1, "t5_setwins_read");
        checkVal("t5_irq_kept", 32'(keyIrq), 32'h1);
        doRead(2'd2, 32'h8, "t5_event_kept");
        checkVal("t5_irq_clr", 32'(keyIrq), 32'h0);
        doRead(2'd3, 32'h0, "t5_no_overrun");
        doRead(2'd0, 32'h9, "t5_pressed");
        KEY = 4'hF;
        tick(8);
        doRead(2'd2, 32'h0, "t5_release_no_event");

        // 6. Switches.
        SW = 10'h2A5;
        tick(7);
        doRead(2'd1, 32'h2A5, "t6_sw");
        tick(3);
        checkVal("t6_hold", rdData, 32'h2A5);
        SW = 10'h0A5;
        tick(2);
        SW = 10'h2A5;
        tick(8);
        doRead(2'd1, 32'h2A5, "t6_sw_glitch");
        SW = 10'h155;
        tick(4);
        reset_n = 1'b0;
        tick(2);
        checkVal("t6_rst_rdData", rdData, 32'h0);
        checkVal("t6_rst_keyIrq", 32'(keyIrq), 32'h0);
        reset_n = 1'b1;
        doRead(2'd1, 32'h0, "t6_sw_after_rst");
        tick(8);
        doRead(2'd1, 32'h155, "t6_sw_recovered");

        for (int w = 0; w < 10 && sbQueue.size() != 0; w++) tick(1);
        checkVal("sb_drained", 32'(sbQueue.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ui_input_sampler.md
Name: ui_input_sampler

Overview:
- Synchronizes, debounces and event-captures the raw board KEY[3:0] and SW[9:0] inputs.
- Presents them as a clean, registered read port for the memory-mapped UI read path, at the KEY and SW addresses.
- Sits directly upstream of the IO read mux: the processor reads debounced levels, sticky key-press events and overrun status instead of raw pins.

Parameters:
- DBITS, 32, read data width.
- KEY_BITS, 4, number of push keys; raw level is active-low.
- SW_BITS, 10, number of slide switches; raw level is active-high.
- DEBOUNCE_CYCLES, 10000, consecutive stable cycles required to accept a new level; legal range 2 to 2^CNT_BITS.
- CNT_BITS, 14, debounce counter width.

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- KEY  in  KEY_BITS  raw keys, asynchronous, 0 = pressed.
- SW  in  SW_BITS  raw switches, asynchronous.
- rdEn  in  1  read strobe, one cycle per read.
- rdSel  in  2  read select: 0 KEYSTATE, 1 SWSTATE, 2 KEYEVENT, 3 STATUS.
- rdData  out  DBITS  registered read data, zero-extended.
- keyIrq  out  1  registered; high while any KEYEVENT bit is set.

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert via clk):
  - sync flops KEY = all 1, SW = all 0.
  - stable KEY = all 1, stable SW = 0.
  - all counters = 0; events = 0; overrun = 0.
  - rdData = 0; keyIrq = 0.
- Synchronizer:
  - Two flops per bit. The second flop output is "synced".
  - Raw-to-synced latency is 2 cycles.
- Debounce, per bit, independent:
  - If synced == stable, counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1, stable <= synced and counter <= 0.
  - Else counter <= counter+1.
  - A glitch shorter than DEBOUNCE_CYCLES synced cycles never changes stable.
  - Minimum raw-to-stable latency is 2 + DEBOUNCE_CYCLES cycles.
- Derived levels:
  - pressed[i] = ~stableKEY[i].
  - swLevel = stableSW.
- Event capture:
  - rise[i] = pressed[i] & ~pressed_d[i]. pressed_d is a registered copy that resets to 0.
  - Release never sets an event.
  - eventSet[i] = rise[i].
  - eventClr = rdEn & rdSel==2.
  - Next event[i] = rise[i] | (event[i] & ~eventClr). When a rise and a clear land in the same cycle, set wins.
  - overrun[i] is set when rise[i] & event[i] & ~eventClr, i.e. a second press arrives before the first was read. It is sticky.
  - eventClr does not touch overrun.
- Read port:
  - When rdEn is high, rdData is updated on the next clk edge (1-cycle latency).
  - When rdEn is low, rdData holds its value.
  - Read contents:
    - sel0 returns {0, pressed}.
    - sel1 returns {0, swLevel}.
    - sel2 returns {0, event}, sampled before that cycle's clear; a same-cycle rise is not included in the returned value but remains set.
    - sel3 returns {0, overrun}, and overrun is cleared to 0, again with set-wins on a same-cycle new overrun.
  - Reads of sel0 and sel1 have no side effects.
- keyIrq <= |next_event; it is registered alongside event.
- Reset mid-debounce discards the partial count. Events pending at reset are lost.
- Counter arithmetic is unsigned CNT_BITS and never wraps; the reload rule above bounds it.

Decomposition:
- Shared package/header:
  - RDSEL_KEYSTATE = 0, RDSEL_SWSTATE = 1, RDSEL_KEYEVENT = 2, RDSEL_STATUS = 3.
  - Reset level constants for KEY (1) and SW (0).
- One natural sub-module, debounce_bit:
  - Contains the 2-flop synchronizer, counter and stable register.
  - Parameterised by DEBOUNCE_CYCLES, CNT_BITS and RESET_LEVEL.
  - Instantiated KEY_BITS + SW_BITS times via generate.
- The top level holds event/overrun logic and the read mux.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4.
1. Reset: hold reset_n=0 with KEY=4'b0000 and SW=10'h3FF, then release -> rdData=0 and keyIrq=0 during reset. Read sel0 at cycle 1 after reset -> 0, because the debounce has not yet completed.
2. Bounce rejection: KEY[0] low for 3 cycles, high 1, low 2, high -> sel0 reads 0 throughout; event=0; keyIrq stays 0.
3. Clean press: KEY[2] low and held -> pressed[2]=1 exactly 6 cycles after the edge. The following cycle gives keyIrq=1. Read sel2 -> rdData=0x4 one cycle later, keyIrq=0 on the next cycle, and a second sel2 read returns 0.
4. Overrun: press/release KEY[1] twice without reading -> sel2 returns 0x2. Then sel3 returns 0x2, and a following sel3 returns 0.
5. Set-wins: arrange rise[3] in the same cycle as an rdEn sel2 read while event[0] is set -> rdData=0x1; event stays 0x8; keyIrq stays 1.
6. Switches: SW=10'h2A5 held for 6+ cycles -> sel1=0x2A5. A toggle of SW[9] lasting 2 cycles leaves the value unchanged. Asserting reset_n=0 mid-count makes the next sel1 read after reset return 0.
